// File: rtl/instr_decode_stage.sv
// RV32I decode stage: all six formats, valid/ready handshakes,
// DEPTH-entry output FIFO that absorbs execute-side backpressure.
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic [2:0]      out_fmt,
  output logic            out_is_jump,
  output logic            out_is_branch,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [2:0]      fmt;
    logic            is_jump;
    logic            is_branch;
    logic [XLEN-1:0] target;
    logic            illegal;
  } dec_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1;
  localparam logic [3:0] A_SLL = 4'd2, A_SLT = 4'd3;
  localparam logic [3:0] A_SLTU = 4'd4, A_XOR = 4'd5;
  localparam logic [3:0] A_SRL = 4'd6, A_SRA = 4'd7;
  localparam logic [3:0] A_OR = 4'd8, A_AND = 4'd9;
  localparam logic [3:0] A_PASSB = 4'd10;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP = 7'b0110011;

  function automatic logic [3:0] f3_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    unique case (f3)
      3'd0:    return alt ? A_SUB : A_ADD;
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd3:    return A_SLTU;
      3'd4:    return A_XOR;
      3'd5:    return alt ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic logic nxt(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b;
  logic [31:0] w_imm_u, w_imm_j;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                    in_instr[11:7]};
  assign w_imm_b = {{20{in_instr[31]}}, in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'd0};
  assign w_imm_j = {{12{in_instr[31]}}, in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [3:0]      w_alu;
  logic [2:0]      w_fmt;
  logic            w_ill, w_jmp, w_br, w_jal;
  dec_t            w_dec;

  always_comb begin
    w_imm32 = w_imm_i;
    w_alu   = A_ADD;
    w_fmt   = F_I;
    w_ill   = 1'b0;
    w_jmp   = 1'b0;
    w_br    = 1'b0;
    w_jal   = 1'b0;
    unique case (w_op)
      OP_LUI: begin
        w_fmt = F_U; w_imm32 = w_imm_u; w_alu = A_PASSB;
      end
      OP_AUIPC: begin
        w_fmt = F_U; w_imm32 = w_imm_u;
      end
      OP_JAL: begin
        w_fmt = F_J; w_imm32 = w_imm_j;
        w_jmp = 1'b1; w_jal = 1'b1;
      end
      OP_JALR: begin
        w_jmp = 1'b1; w_ill = (w_f3 != 3'd0);
      end
      OP_BR: begin
        w_fmt = F_B; w_imm32 = w_imm_b;
        w_br = 1'b1; w_alu = A_SUB;
        w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      OP_LOAD: begin
        w_ill = (w_f3 == 3'd3) || (w_f3 >= 3'd6);
      end
      OP_STORE: begin
        w_fmt = F_S; w_imm32 = w_imm_s;
        w_ill = (w_f3 > 3'd2);
      end
      OP_IMM: begin
        // SUB has no immediate form; only shifts look at funct7
        w_alu = f3_alu(w_f3, (w_f3 == 3'd5) && w_f7[5]);
        if (w_f3 == 3'd1)
          w_ill = (w_f7 != 7'h00);
        else if (w_f3 == 3'd5)
          w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
      end
      OP_OP: begin
        w_fmt = F_R; w_imm32 = '0;
        w_alu = f3_alu(w_f3, w_f7 == 7'h20);
        if (w_f7 == 7'h20)
          w_ill = (w_f3 != 3'd0) && (w_f3 != 3'd5);
        else
          w_ill = (w_f7 != 7'h00);
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  always_comb begin
    w_dec = '0;
    w_dec.pc = in_pc;
    if (w_ill) begin
      w_dec.fmt = F_I;
      w_dec.illegal = 1'b1;
    end else begin
      w_dec.fmt = w_fmt;
      w_dec.alu_op = w_alu;
      w_dec.imm = w_imm;
      w_dec.is_jump = w_jmp;
      w_dec.is_branch = w_br;
      if (w_fmt != F_S && w_fmt != F_B)
        w_dec.rd = in_instr[11:7];
      if (w_fmt != F_U && w_fmt != F_J)
        w_dec.rs1 = in_instr[19:15];
      if (w_fmt == F_R || w_fmt == F_S || w_fmt == F_B)
        w_dec.rs2 = in_instr[24:20];
      if (w_jal || w_br)
        w_dec.target = in_pc + w_imm;
    end
  end

  dec_t       r_mem [DEPTH];
  logic       r_head, r_tail;
  logic [1:0] r_count;
  logic       w_push, w_pop;
  dec_t       w_head;

  assign in_ready  = (r_count < 2'(DEPTH));
  assign out_valid = (r_count != 2'd0);
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_push) r_tail <= nxt(r_tail);
      if (w_pop)  r_head <= nxt(r_head);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_tail] <= w_dec;
    end
  end

  // empty buffer presents a zeroed entry tagged with RESET_PC_TAG
  always_comb begin
    w_head = '0;
    w_head.pc = RESET_PC_TAG;
    if (out_valid) w_head = r_mem[r_head];
  end

  assign out_pc        = w_head.pc;
  assign out_rd        = w_head.rd;
  assign out_rs1       = w_head.rs1;
  assign out_rs2       = w_head.rs2;
  assign out_imm       = w_head.imm;
  assign out_alu_op    = w_head.alu_op;
  assign out_fmt       = w_head.fmt;
  assign out_is_jump   = w_head.is_jump;
  assign out_is_branch = w_head.is_branch;
  assign out_target    = w_head.target;
  assign out_illegal   = w_head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, backpressure,
// flush, async reset, and a 64-bit single-entry instance.
module tb_instr_decode_stage;

  localparam logic [31:0] TAG = 32'hCAFE_0000;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm, out_target;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_fmt;
  logic        out_is_jump, out_is_branch, out_illegal;

  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [31:0] f_in_instr;
  logic [63:0] f_in_pc, f_out_pc, f_out_imm, f_out_target;
  logic [4:0]  f_out_rd, f_out_rs1, f_out_rs2;
  logic [3:0]  f_out_alu_op;
  logic [2:0]  f_out_fmt;
  logic        f_out_is_jump, f_out_is_branch, f_out_illegal;

  int tests_run = 0;
  int tests_failed = 0;

  instr_decode_stage #(.XLEN(32), .DEPTH(2), .RESET_PC_TAG(TAG)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_fmt(out_fmt), .out_is_jump(out_is_jump),
    .out_is_branch(out_is_branch), .out_target(out_target),
    .out_illegal(out_illegal)
  );

  instr_decode_stage #(.XLEN(64), .DEPTH(1), .RESET_PC_TAG(64'h0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_instr(f_in_instr), .in_pc(f_in_pc),
    .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_pc(f_out_pc), .out_rd(f_out_rd), .out_rs1(f_out_rs1),
    .out_rs2(f_out_rs2), .out_imm(f_out_imm), .out_alu_op(f_out_alu_op),
    .out_fmt(f_out_fmt), .out_is_jump(f_out_is_jump),
    .out_is_branch(f_out_is_branch), .out_target(f_out_target),
    .out_illegal(f_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;
    f_in_valid = 1'b0; f_in_instr = '0; f_in_pc = '0; f_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_hs: got %b want 01", {out_valid, in_ready});
    end
    tests_run++;
    if (out_pc !== TAG) begin
      tests_failed++;
      $display("FAIL reset_pc: got %h want %h", out_pc, TAG);
    end
    tests_run++;
    if ({out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_fmt,
         out_is_jump, out_is_branch, out_target, out_illegal} !== '0) begin
      tests_failed++;
      $display("FAIL reset_fields: got rd=%0d imm=%h fmt=%0d want 0",
               out_rd, out_imm, out_fmt);
    end
  endtask

  task automatic test_jal;
    out_ready = 1'b1;
    push(32'h004000EF, 32'h100);
    tests_run++;
    if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin
      tests_failed++;
      $display("FAIL jal_valid: got %b/%h want 1/100", out_valid, out_pc);
    end
    tests_run++;
    if ({out_rd, out_rs1, out_rs2} !== {5'd1, 5'd0, 5'd0}) begin
      tests_failed++;
      $display("FAIL jal_regs: got %0d/%0d/%0d want 1/0/0",
               out_rd, out_rs1, out_rs2);
    end
    tests_run++;
    if ({out_imm, out_target} !== {32'h4, 32'h104}) begin
      tests_failed++;
      $display("FAIL jal_imm: got %h/%h want 4/104", out_imm, out_target);
    end
    tests_run++;
    if ({out_fmt, out_alu_op, out_is_jump, out_is_branch, out_illegal}
        !== {3'd5, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL jal_ctl: got fmt=%0d alu=%0d j=%b b=%b ill=%b",
               out_fmt, out_alu_op, out_is_jump, out_is_branch, out_illegal);
    end
    push(32'hFFDFF0EF, 32'h200);
    tests_run++;
    if ({out_rd, out_imm, out_target} !== {5'd1, 32'hFFFFFFFC, 32'h1FC}) begin
      tests_failed++;
      $display("FAIL jal_neg: got rd=%0d imm=%h tgt=%h want 1/fffffffc/1fc",
               out_rd, out_imm, out_target);
    end
    push(32'hFFDFF0EF, 32'h0);
    tests_run++;
    if (out_target !== 32'hFFFFFFFC) begin
      tests_failed++;
      $display("FAIL jal_wrap: got %h want fffffffc", out_target);
    end
  endtask

  task automatic test_addi;
    push(32'hFFF30293, 32'h400);
    tests_run++;
    if ({out_rd, out_rs1, out_rs2} !== {5'd5, 5'd6, 5'd0}) begin
      tests_failed++;
      $display("FAIL addi_regs: got %0d/%0d/%0d want 5/6/0",
               out_rd, out_rs1, out_rs2);
    end
    tests_run++;
    if ({out_imm, out_fmt, out_alu_op, out_illegal, out_target, out_is_jump}
        !== {32'hFFFFFFFF, 3'd1, 4'd0, 1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL addi_ctl: got imm=%h fmt=%0d alu=%0d ill=%b tgt=%h",
               out_imm, out_fmt, out_alu_op, out_illegal, out_target);
    end
  endtask

  task automatic test_illegal;
    push(32'h00000000, 32'h500);
    tests_run++;
    if ({out_valid, out_pc, out_illegal, out_fmt} !== {1'b1, 32'h500, 1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL ill_zero: got v=%b pc=%h ill=%b fmt=%0d want 1/500/1/1",
               out_valid, out_pc, out_illegal, out_fmt);
    end
    tests_run++;
    if ({out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_target,
         out_is_jump, out_is_branch} !== '0) begin
      tests_failed++;
      $display("FAIL ill_fields: got rd=%0d rs1=%0d imm=%h want 0",
               out_rd, out_rs1, out_imm);
    end
    push(32'h40005033, 32'h504);
    tests_run++;
    if ({out_illegal, out_alu_op, out_fmt, out_imm} !== {1'b0, 4'd7, 3'd0, 32'h0}) begin
      tests_failed++;
      $display("FAIL sra: got ill=%b alu=%0d fmt=%0d imm=%h want 0/7/0/0",
               out_illegal, out_alu_op, out_fmt, out_imm);
    end
    push(32'h00002063, 32'h508);
    tests_run++;
    if (out_illegal !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_br_f3: got %b want 1", out_illegal);
    end
    push(32'h02000033, 32'h50C);
    tests_run++;
    if (out_illegal !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_op_f7: got %b want 1", out_illegal);
    end
  endtask

  task automatic test_formats;
    push(32'h00208463, 32'h300);
    tests_run++;
    if ({out_rd, out_rs1, out_rs2, out_imm, out_target}
        !== {5'd0, 5'd1, 5'd2, 32'h8, 32'h308}) begin
      tests_failed++;
      $display("FAIL beq_fields: got rd=%0d rs=%0d/%0d imm=%h tgt=%h",
               out_rd, out_rs1, out_rs2, out_imm, out_target);
    end
    tests_run++;
    if ({out_fmt, out_alu_op, out_is_branch, out_is_jump}
        !== {3'd3, 4'd1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL beq_ctl: got fmt=%0d alu=%0d b=%b j=%b want 3/1/1/0",
               out_fmt, out_alu_op, out_is_branch, out_is_jump);
    end
    push(32'h0020A223, 32'h310);
    tests_run++;
    if ({out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_alu_op, out_target}
        !== {5'd0, 5'd1, 5'd2, 32'h4, 3'd2, 4'd0, 32'h0}) begin
      tests_failed++;
      $display("FAIL sw: got rd=%0d rs=%0d/%0d imm=%h fmt=%0d alu=%0d",
               out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_alu_op);
    end
    push(32'h800003B7, 32'h320);
    tests_run++;
    if ({out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_alu_op}
        !== {5'd7, 5'd0, 5'd0, 32'h80000000, 3'd4, 4'd10}) begin
      tests_failed++;
      $display("FAIL lui: got rd=%0d rs1=%0d imm=%h fmt=%0d alu=%0d",
               out_rd, out_rs1, out_imm, out_fmt, out_alu_op);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx [4];
    int got;
    got = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF30293; in_pc = 32'h1000;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready1: got %b want 1", in_ready);
    end
    @(negedge clk); in_pc = 32'h1004;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_pc} !== {1'b0, 32'h1000}) begin
      tests_failed++;
      $display("FAIL bp_full: got rdy=%b pc=%h want 0/1000", in_ready, out_pc);
    end
    @(negedge clk); in_pc = 32'h1008;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_valid, out_pc, out_rd} !== {1'b0, 1'b1, 32'h1000, 5'd5}) begin
      tests_failed++;
      $display("FAIL bp_hold: got rdy=%b v=%b pc=%h want 0/1/1000",
               in_ready, out_valid, out_pc);
    end
    @(negedge clk); out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic acc;
      acc = in_valid && in_ready;
      if (out_valid && out_ready && got < 4) begin
        rx[got] = out_pc;
        got++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (got !== 3) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d want 3", got);
    end else begin
      tests_run++;
      if ({rx[0], rx[1], rx[2]} !== {32'h1000, 32'h1004, 32'h1008}) begin
        tests_failed++;
        $display("FAIL bp_order: got %h %h %h want 1000 1004 1008",
                 rx[0], rx[1], rx[2]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    push(32'hFFF30293, 32'h2000);
    push(32'hFFF30293, 32'h2004);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_pre: got in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h2008;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, TAG}) begin
      tests_failed++;
      $display("FAIL flush_full: got v=%b rdy=%b pc=%h want 0/1/%h",
               out_valid, in_ready, out_pc, TAG);
    end
    push(32'hFFF30293, 32'h3000);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h3004;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: got out_valid=%b pc=%h want 0",
               out_valid, out_pc);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    push(32'hFFF30293, 32'h4000);
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h4004;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, out_pc, out_rd, out_imm} !==
        {1'b0, 1'b1, TAG, 5'd0, 32'h0}) begin
      tests_failed++;
      $display("FAIL async_rst: got v=%b rdy=%b pc=%h rd=%0d want 0/1/%h/0",
               out_valid, in_ready, out_pc, out_rd, TAG);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_release: got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    push(32'hFFF30293, 32'h5000);
    tests_run++;
    if ({out_valid, out_pc} !== {1'b1, 32'h5000}) begin
      tests_failed++;
      $display("FAIL rst_resume: got v=%b pc=%h want 1/5000", out_valid, out_pc);
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_xlen64;
    @(negedge clk);
    f_out_ready = 1'b0; f_in_valid = 1'b1;
    f_in_instr = 32'hFFDFF0EF; f_in_pc = 64'h200;
    @(posedge clk); #1;
    f_in_instr = 32'h800003B7; f_in_pc = 64'h300;
    tests_run++;
    if ({f_out_imm, f_out_target} !== {64'hFFFF_FFFF_FFFF_FFFC, 64'h1FC}) begin
      tests_failed++;
      $display("FAIL x64_jal: got imm=%h tgt=%h", f_out_imm, f_out_target);
    end
    tests_run++;
    if ({f_out_valid, f_in_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL x64_full: got %b want 10", {f_out_valid, f_in_ready});
    end
    @(negedge clk); f_out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({f_out_valid, f_in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL x64_norefill: got %b want 01", {f_out_valid, f_in_ready});
    end
    @(posedge clk); #1;
    f_in_valid = 1'b0;
    tests_run++;
    if ({f_out_valid, f_out_pc, f_out_imm} !==
        {1'b1, 64'h300, 64'hFFFF_FFFF_8000_0000}) begin
      tests_failed++;
      $display("FAIL x64_lui: got v=%b pc=%h imm=%h", f_out_valid, f_out_pc, f_out_imm);
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_addi();
    test_illegal();
    test_formats();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Pipelined, parametrised RV32I decode stage: successor to the per-format decoders, covering all six formats (R/I/S/B/U/J) in one block.
Sits between fetch and execute. Inputs and outputs use valid/ready handshakes, with a 2-entry output buffer that absorbs execute-side backpressure.
Emits register indices, the sign-extended immediate, ALU op, format and control flags, an illegal-instruction flag, and the precomputed PC-relative target for JAL and branches.

Parameters:
XLEN, 32, datapath width of pc, immediate and target (32 or 64); immediates sign-extended to XLEN
DEPTH, 2, output buffer entries (legal values 1 or 2); 1 gives a plain pipeline register
RESET_PC_TAG, 0, value driven on out_pc while the buffer is empty

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; discards all buffered entries
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept an instruction this cycle
in_instr  in  32  raw instruction
in_pc  in  XLEN  pc of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head entry
out_pc  out  XLEN  pc of head entry
out_rd  out  5  destination register; 0 for S/B formats
out_rs1  out  5  source 1; 0 for U/J formats
out_rs2  out  5  source 2; 0 unless R/S/B format
out_imm  out  XLEN  sign-extended immediate; 0 for R format
out_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
out_fmt  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J
out_is_jump  out  1  JAL or JALR
out_is_branch  out  1  B format
out_target  out  XLEN  pc+imm for JAL/B; 0 otherwise (JALR target resolved in execute)
out_illegal  out  1  unsupported opcode or funct encoding

Behaviour:
- Decode is combinational on in_instr/in_pc; the result is written into the buffer at the tail on a push, i.e. when in_valid && in_ready.
- Latency is 1 cycle: an instruction pushed at edge N is visible on out_* after edge N with out_valid=1.
- The buffer is a FIFO of DEPTH entries; count ranges 0..DEPTH.
- in_ready = (count < DEPTH); it is registered-state-derived only, with no combinational path from out_ready.
- Pop occurs when out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- When count=DEPTH, in_ready=0 and no push is possible even if a pop occurs that cycle (no same-cycle refill).
- out_* holds the head entry and is stable while out_valid && !out_ready.
- When the buffer is empty: out_valid=0, out_pc=RESET_PC_TAG, and all other outputs are 0.
- flush: count goes to 0 next cycle and any same-cycle push is dropped. flush dominates in_valid and out_ready.
- Reset (async, any time including mid-transfer): count=0, out_valid=0, all outputs 0, out_pc=RESET_PC_TAG. in_ready=1 after reset release.
- Immediates are built from instruction bits per RISC-V I/S/B/U/J layouts and sign-extended from bit 31.
- U-type immediate is inst[31:12]<<12, sign-extended to XLEN.
- out_target = in_pc + imm, computed modulo 2^XLEN (wrap-around, no flag).
- ALU op mapping:
  - OP/OP-IMM use funct3 (and funct7[5] for SUB/SRA; SUB only in OP).
  - LUI → PASS_B.
  - AUIPC, loads, stores, JAL, JALR → ADD.
  - Branches → SUB.
- Legal opcodes are LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP. Any other opcode sets out_illegal=1, with fmt=I and all other fields 0.
- Specific illegal encodings:
  - BRANCH with funct3 2 or 3.
  - LOAD with funct3 3, 6 or 7.
  - STORE with funct3 above 2.
  - JALR with funct3 not equal to 0.
  - OP with funct7 other than 0 or 0x20 (0x20 valid only for funct3 0 and 5).
  - OP-IMM shifts with an invalid funct7.
- Illegal entries still flow through the handshake like any other entry.

Test Plan:
- in_instr=0x004000EF, in_pc=0x100, out_ready=1 → next cycle out_valid=1, rd=1, imm=0x4, fmt=J, is_jump=1, target=0x104, alu_op=ADD.
- in_instr=0xFFDFF0EF, in_pc=0x200 → rd=1, imm=0xFFFFFFFC, target=0x1FC. With XLEN=64: imm=0xFFFFFFFFFFFFFFFC.
- in_instr=0xFFF30293 (addi x5,x6,-1) → rd=5, rs1=6, rs2=0, imm=0xFFFFFFFF, fmt=I, alu_op=ADD, illegal=0.
- in_instr=0x00000000, then 0x40005033 (funct7=0x20, funct3=5, SRA) → first illegal=1; second illegal=0, alu_op=SRA(7).
- out_ready=0, push 3 back-to-back instructions (DEPTH=2) → in_ready drops after 2nd push and the 3rd is held by fetch. Raising out_ready then delivers all 3 in order with no loss or duplication.
- With 2 entries buffered, assert flush together with in_valid → next cycle out_valid=0, count=0, in_ready=1. Then assert rst_n=0 mid-push → outputs clear immediately, without waiting for a clock edge.
